// File: rtl/usermem_arbiter.sv
// usermem_arbiter: round-robin arbiter sharing the 256x8 user memory
// between the CPU (port 0) and a DMA/debug master (port 1).
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   cpu_* / dma_*         req, lock, we, addr, wdata in; gnt, rdata, rvalid out
//   usermem_address       memory address (IDLE_ADDR when no grant)
//   usermem_data          bidirectional data, driven only on a granted write
//   rw                    memory write strobe
//
// Optional feature (macro USERMEM_ARB_STATS_EN): adds 16-bit wrapping
// counters cpu_gnt_cnt, dma_gnt_cnt and conflict_cnt.
module usermem_arbiter #(
    parameter int unsigned MAX_BURST = 4,
    parameter logic [7:0]  IDLE_ADDR = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic       cpu_lock,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_gnt,
    output logic [7:0] cpu_rdata,
    output logic       cpu_rvalid,
    input  logic       dma_req,
    input  logic       dma_lock,
    input  logic       dma_we,
    input  logic [7:0] dma_addr,
    input  logic [7:0] dma_wdata,
    output logic       dma_gnt,
    output logic [7:0] dma_rdata,
    output logic       dma_rvalid,
    output logic [7:0] usermem_address,
    inout  wire  [7:0] usermem_data,
    output logic       rw
`ifdef USERMEM_ARB_STATS_EN
    ,
    output logic [15:0] cpu_gnt_cnt,
    output logic [15:0] dma_gnt_cnt,
    output logic [15:0] conflict_cnt
`endif
);

    localparam logic [3:0] BMAX = 4'(MAX_BURST);

    logic       last;
    logic [3:0] bcnt;

    logic       pick;
    logic       any;
    logic       last_lock;
    logic       win_lock;
    logic       win_we;
    logic [7:0] win_addr;
    logic [7:0] win_wdata;

    // pick selects the port that would win; any gates it with reset
    always_comb begin
        last_lock = last ? dma_lock : cpu_lock;
        pick      = dma_req;
        if (cpu_req && dma_req)
            pick = (last_lock && bcnt < BMAX) ? last : !last;
        any       = reset && (cpu_req || dma_req);
        cpu_gnt   = any && !pick;
        dma_gnt   = any && pick;
        win_lock  = pick ? dma_lock  : cpu_lock;
        win_we    = pick ? dma_we    : cpu_we;
        win_addr  = pick ? dma_addr  : cpu_addr;
        win_wdata = pick ? dma_wdata : cpu_wdata;
        usermem_address = any ? win_addr : IDLE_ADDR;
        rw        = any && win_we;
    end

    assign usermem_data = rw ? win_wdata : 8'bz;

    always_ff @(posedge clk) begin
        if (!reset) begin
            last       <= 1'b1;
            bcnt       <= 4'd0;
            cpu_rdata  <= 8'h00;
            dma_rdata  <= 8'h00;
            cpu_rvalid <= 1'b0;
            dma_rvalid <= 1'b0;
        end else begin
            cpu_rvalid <= 1'b0;
            dma_rvalid <= 1'b0;
            if (any) begin
                last <= pick;
                // count only grants that continue a locked ownership
                if (pick == last && win_lock)
                    bcnt <= (bcnt < BMAX) ? bcnt + 4'd1 : BMAX;
                else
                    bcnt <= 4'd0;
                if (!win_we) begin
                    if (pick) begin
                        dma_rdata  <= usermem_data;
                        dma_rvalid <= 1'b1;
                    end else begin
                        cpu_rdata  <= usermem_data;
                        cpu_rvalid <= 1'b1;
                    end
                end
            end else begin
                bcnt <= 4'd0;
            end
        end
    end

`ifdef USERMEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            cpu_gnt_cnt  <= 16'd0;
            dma_gnt_cnt  <= 16'd0;
            conflict_cnt <= 16'd0;
        end else begin
            if (cpu_gnt)
                cpu_gnt_cnt <= cpu_gnt_cnt + 16'd1;
            if (dma_gnt)
                dma_gnt_cnt <= dma_gnt_cnt + 16'd1;
            if (cpu_req && dma_req)
                conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_usermem_arbiter.sv
// tb_usermem_arbiter: scoreboard bench for usermem_arbiter with a
// behavioural memory and arbitration model.
module tb_usermem_arbiter;

    localparam int MAXB = 4;
    localparam logic [7:0] IDLE = 8'h00;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cpu_req = 0, cpu_lock = 0, cpu_we = 0;
    logic [7:0] cpu_addr = 0, cpu_wdata = 0;
    logic       dma_req = 0, dma_lock = 0, dma_we = 0;
    logic [7:0] dma_addr = 0, dma_wdata = 0;
    logic       cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, rw;
    logic [7:0] cpu_rdata, dma_rdata, usermem_address;
    wire  [7:0] usermem_data;
`ifdef USERMEM_ARB_STATS_EN
    logic [15:0] cpu_gnt_cnt, dma_gnt_cnt, conflict_cnt;
`endif

    always #5 clk = ~clk;

    usermem_arbiter #(.MAX_BURST(MAXB), .IDLE_ADDR(IDLE)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_lock(cpu_lock), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
        .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dma_req(dma_req), .dma_lock(dma_lock), .dma_we(dma_we),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
        .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .usermem_address(usermem_address), .usermem_data(usermem_data),
        .rw(rw)
`ifdef USERMEM_ARB_STATS_EN
        , .cpu_gnt_cnt(cpu_gnt_cnt), .dma_gnt_cnt(dma_gnt_cnt),
        .conflict_cnt(conflict_cnt)
`endif
    );

    // environment memory: combinational read, negedge write
    logic [7:0] mem [256];
    assign usermem_data = rw ? 8'bz : mem[usermem_address];
    always @(negedge clk) if (rw) mem[usermem_address] = usermem_data;

    typedef struct {
        bit         req;
        bit         lock;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } txn_t;

    txn_t       cur [2];
    logic [7:0] ref_mem [256];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    bit         rst_drv = 0;
    int         m_last = 1;
    int         m_run = 0;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference arbitration: owner keeps a locked contested grant until
    // it has held MAXB consecutive locked grants
    function automatic int model_pick();
        bit lk;
        if (!cur[0].req && !cur[1].req) return -1;
        if (cur[0].req && !cur[1].req) return 0;
        if (cur[1].req && !cur[0].req) return 1;
        lk = cur[m_last].lock;
        if (lk && m_run < MAXB) return m_last;
        return 1 - m_last;
    endfunction

    task automatic set_t(int p, bit rq, bit lk, bit we,
                         logic [7:0] a, logic [7:0] d);
        cur[p].req = rq; cur[p].lock = lk; cur[p].we = we;
        cur[p].addr = a; cur[p].wdata = d;
    endtask

    task automatic do_cycle(output int w);
        int exp_rw;
        int exp_addr;
        @(posedge clk); #2;
        reset     = rst_drv;
        cpu_req   = cur[0].req;  cpu_lock = cur[0].lock; cpu_we = cur[0].we;
        cpu_addr  = cur[0].addr; cpu_wdata = cur[0].wdata;
        dma_req   = cur[1].req;  dma_lock = cur[1].lock; dma_we = cur[1].we;
        dma_addr  = cur[1].addr; dma_wdata = cur[1].wdata;
        #2;
        w = rst_drv ? model_pick() : -1;
        exp_rw   = (w >= 0) ? int'(cur[w].we) : 0;
        exp_addr = (w >= 0) ? int'(cur[w].addr) : int'(IDLE);
        chk("cpu_gnt", cpu_gnt, (w == 0) ? 1 : 0);
        chk("dma_gnt", dma_gnt, (w == 1) ? 1 : 0);
        chk("rw", rw, exp_rw);
        chk("usermem_address", usermem_address, exp_addr);
        if (!rst_drv) begin
            m_last = 1; m_run = 0;
        end else if (w < 0) begin
            m_run = 0;
        end else begin
            if (w == m_last && cur[w].lock)
                m_run = (m_run < MAXB) ? m_run + 1 : MAXB;
            else
                m_run = 0;
            m_last = w;
            if (cur[w].we) ref_mem[cur[w].addr] = cur[w].wdata;
            else if (w == 0) q0.push_back(ref_mem[cur[w].addr]);
            else q1.push_back(ref_mem[cur[w].addr]);
        end
    endtask

    task automatic dcyc(int exp_w);
        int w;
        int dw;
        do_cycle(w);
        dw = cpu_gnt ? 0 : (dma_gnt ? 1 : -1);
        chk("directed grant", dw, exp_w);
    endtask

    // monitor: every queued read must complete on the next posedge
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk); #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("cpu_rvalid", cpu_rvalid, 1);
                chk("cpu_rdata", cpu_rdata, e);
            end else begin
                chk("cpu_rvalid idle", cpu_rvalid, 0);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("dma_rvalid", dma_rvalid, 1);
                chk("dma_rdata", dma_rdata, e);
            end else begin
                chk("dma_rvalid idle", dma_rvalid, 0);
            end
        end
    end

    initial begin
        int w;
        bit pend [2];
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h00; ref_mem[i] = 8'h00;
        end
        mem[1] = 8'h33; ref_mem[1] = 8'h33;
        mem[2] = 8'hAA; ref_mem[2] = 8'hAA;
        set_t(0, 0, 0, 0, 0, 0);
        set_t(1, 0, 0, 0, 0, 0);

        // reset held with a CPU write pending
        rst_drv = 0;
        set_t(0, 1, 0, 1, 8'h05, 8'hFF);
        repeat (3) dcyc(-1);
        chk("cpu_rdata reset", cpu_rdata, 8'h00);
        chk("dma_rdata reset", dma_rdata, 8'h00);
        chk("mem unchanged in reset", mem[5], 8'h00);

        // CPU read of address 1
        rst_drv = 1;
        set_t(0, 1, 0, 0, 8'h01, 8'h00);
        dcyc(0);
        set_t(0, 0, 0, 0, 0, 0);
        dcyc(-1);
        chk("cpu_rdata read 1", cpu_rdata, 8'h33);

        // DMA write then read back
        set_t(1, 1, 0, 1, 8'h10, 8'h5C);
        dcyc(1);
        set_t(1, 1, 0, 0, 8'h10, 8'h00);
        dcyc(1);
        set_t(1, 0, 0, 0, 0, 0);
        dcyc(-1);
        chk("dma_rdata readback", dma_rdata, 8'h5C);
        chk("mem[10] written", mem[8'h10], 8'h5C);

        // contention without lock alternates
        rst_drv = 0; dcyc(-1); rst_drv = 1;
        set_t(0, 1, 0, 0, 8'h02, 0);
        set_t(1, 1, 0, 0, 8'h01, 0);
        dcyc(0); dcyc(1); dcyc(0); dcyc(1);

        // CPU lock: 1 + MAXB grants, then DMA once, then CPU
        rst_drv = 0; dcyc(-1); rst_drv = 1;
        set_t(0, 1, 1, 0, 8'h02, 0);
        set_t(1, 1, 0, 0, 8'h10, 0);
        repeat (MAXB + 1) dcyc(0);
        dcyc(1);
        dcyc(0);
        set_t(1, 0, 0, 0, 0, 0);
        repeat (20) dcyc(0);
        set_t(0, 0, 0, 0, 0, 0);
        dcyc(-1);

`ifdef USERMEM_ARB_STATS_EN
        rst_drv = 0; dcyc(-1); rst_drv = 1;
        set_t(0, 1, 0, 0, 8'h01, 0);
        set_t(1, 1, 0, 0, 8'h02, 0);
        for (int i = 0; i < 10; i++) dcyc(i % 2);
        set_t(0, 0, 0, 0, 0, 0);
        set_t(1, 0, 0, 0, 0, 0);
        dcyc(-1);
        chk("cpu_gnt_cnt", cpu_gnt_cnt, 5);
        chk("dma_gnt_cnt", dma_gnt_cnt, 5);
        chk("conflict_cnt", conflict_cnt, 10);
        rst_drv = 0; dcyc(-1); rst_drv = 1;
        dcyc(-1);
        chk("cpu_gnt_cnt reset", cpu_gnt_cnt, 0);
        chk("dma_gnt_cnt reset", dma_gnt_cnt, 0);
        chk("conflict_cnt reset", conflict_cnt, 0);
`endif

        // randomized traffic, requesters hold until granted
        pend[0] = 0; pend[1] = 0;
        for (int n = 0; n < 500; n++) begin
            rst_drv = ($urandom_range(59) != 0);
            for (int p = 0; p < 2; p++) begin
                if (!pend[p]) begin
                    set_t(p, ($urandom_range(9) < 7),
                          ($urandom_range(2) == 0), $urandom_range(1) != 0,
                          8'($urandom_range(15)), 8'($urandom));
                    pend[p] = cur[p].req;
                end
            end
            do_cycle(w);
            if (!rst_drv) begin
                pend[0] = 0; pend[1] = 0;
            end else if (w >= 0) begin
                pend[w] = 0;
            end
        end
        rst_drv = 1;
        set_t(0, 0, 0, 0, 0, 0);
        set_t(1, 0, 0, 0, 0, 0);
        dcyc(-1);
        dcyc(-1);
        chk("cpu queue drained", q0.size(), 0);
        chk("dma queue drained", q1.size(), 0);
        for (int i = 0; i < 256; i++)
            chk("memory contents", mem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
